// File: rtl/branch_pkg.sv
// Shared definitions for the branch-condition resolver.
//   cond_e     : condition codes carried on cond_op
//   state_e    : resolver FSM states
//   nsl_of     : number of compare slices for a given operand/slice width
//   is_signed_op / branch_taken : decode helpers for the condition code
package branch_pkg;

  typedef enum logic [2:0] {
    CondBeq  = 3'b000,
    CondBne  = 3'b001,
    CondBle  = 3'b010,
    CondBgt  = 3'b011,
    CondBlt  = 3'b100,
    CondBge  = 3'b101,
    CondBleu = 3'b110,
    CondBgtu = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCmp  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic int unsigned nsl_of(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  function automatic logic is_signed_op(input cond_e op);
    return !(op == CondBleu || op == CondBgtu);
  endfunction

  function automatic logic branch_taken(input cond_e op, input logic eq, input logic gt,
                                        input logic lt);
    logic taken;
    unique case (op)
      CondBeq:           taken = eq;
      CondBne:           taken = !eq;
      CondBle, CondBleu: taken = !gt;
      CondBgt, CondBgtu: taken = gt;
      CondBlt:           taken = lt;
      CondBge:           taken = !lt;
      default:           taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// Combinational unsigned comparator for one operand slice.
//   a_i, b_i : SLICE-bit slices
//   eq_o     : a_i == b_i
//   gt_o     : a_i >  b_i (unsigned)
module slice_cmp #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/branch_cond_unit.sv
// Multicycle branch-condition resolver. Latches two operands and a condition
// code on start, compares them MSB-first one slice per cycle (stopping at the
// first differing slice), then pulses done with registered flags and the
// taken decision. Also keeps a saturating count of taken branches.
//   clk, reset          : clock, synchronous active-high reset
//   start, cond_op, a, b: request and its operands (sampled in idle only)
//   clear_count         : synchronous clear of taken_count
//   busy, done          : request in flight / one-cycle result pulse
//   igual, maior, menor : registered ==, >, < under the op's signedness
//   update_UC_out       : registered taken decision
//   taken_count         : saturating taken counter
module branch_cond_unit
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cond_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clear_count,
  output logic             busy,
  output logic             done,
  output logic             igual,
  output logic             maior,
  output logic             menor,
  output logic             update_UC_out,
  output logic [CNT_W-1:0] taken_count
);

  if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_slice
    $error("branch_cond_unit: WIDTH must be a non-zero multiple of SLICE");
  end

  localparam int unsigned Nsl  = nsl_of(WIDTH, SLICE);
  localparam int unsigned IdxW = (Nsl > 1) ? $clog2(Nsl) : 1;

  state_e           state_q;
  cond_e            op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IdxW-1:0]  idx_q;
  logic             busy_q, done_q;
  logic             igual_q, maior_q, menor_q, taken_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] sign_mask;
  logic [SLICE-1:0] a_sl, b_sl;
  logic             sl_eq, sl_gt;
  logic             finish;
  logic             res_eq, res_gt, res_lt, res_taken;

  // Flipping the sign bit at latch time maps two's complement onto an
  // unsigned ordering, so the slice comparator never needs to know the op.
  always_comb begin
    sign_mask            = '0;
    sign_mask[WIDTH-1]   = is_signed_op(cond_e'(cond_op));
  end

  always_comb begin
    a_sl = a_q[int'(idx_q) * SLICE +: SLICE];
    b_sl = b_q[int'(idx_q) * SLICE +: SLICE];
  end

  slice_cmp #(
    .SLICE (SLICE)
  ) u_slice_cmp (
    .a_i  (a_sl),
    .b_i  (b_sl),
    .eq_o (sl_eq),
    .gt_o (sl_gt)
  );

  // A differing slice decides the result; equality needs the last slice.
  always_comb begin
    finish    = (state_q == StCmp) && (!sl_eq || (idx_q == '0));
    res_eq    = sl_eq;
    res_gt    = !sl_eq && sl_gt;
    res_lt    = !sl_eq && !sl_gt;
    res_taken = branch_taken(op_q, res_eq, res_gt, res_lt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= CondBeq;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      igual_q <= 1'b0;
      maior_q <= 1'b0;
      menor_q <= 1'b0;
      taken_q <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a ^ sign_mask;
            b_q     <= b ^ sign_mask;
            op_q    <= cond_e'(cond_op);
            idx_q   <= IdxW'(Nsl - 1);
            busy_q  <= 1'b1;
            state_q <= StCmp;
          end
        end
        StCmp: begin
          if (finish) begin
            igual_q <= res_eq;
            maior_q <= res_gt;
            menor_q <= res_lt;
            taken_q <= res_taken;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Clear has priority over a coincident increment.
      if (clear_count) begin
        count_q <= '0;
      end else if (finish && res_taken && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign igual         = igual_q;
  assign maior         = maior_q;
  assign menor         = menor_q;
  assign update_UC_out = taken_q;
  assign taken_count   = count_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

  localparam int W    = 32;
  localparam int S    = 8;
  localparam int NSL  = W / S;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, clear_count;
  logic [2:0]    cond_op;
  logic [W-1:0]  a, b;
  logic          busy, done, igual, maior, menor, update_UC_out;
  logic [CW-1:0] taken_count;

  int total = 0;
  int bad   = 0;
  int model_count = 0;

  branch_cond_unit #(
    .WIDTH (W),
    .SLICE (S),
    .CNT_W (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cond_op       (cond_op),
    .a             (a),
    .b             (b),
    .clear_count   (clear_count),
    .busy          (busy),
    .done          (done),
    .igual         (igual),
    .maior         (maior),
    .menor         (menor),
    .update_UC_out (update_UC_out),
    .taken_count   (taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic        eq;
    logic        gt;
    logic        lt;
    logic        tk;
    int          j;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic plus the taken rules, and j
  // as the first differing slice counted from the MSB.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic eq, output logic gt, output logic lt, output logic tk,
                       output int j);
    logic found;
    eq = (x == y);
    if (op == 3'b110 || op == 3'b111) begin
      gt = x > y;
      lt = x < y;
    end else begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end
    case (op)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b010, 3'b110: tk = !gt;
      3'b011, 3'b111: tk = gt;
      3'b100:         tk = lt;
      default:        tk = !lt;
    endcase
    j = NSL;
    found = 1'b0;
    for (int k = 1; k <= NSL; k++) begin
      if (!found && (x[(NSL - k) * S +: S] != y[(NSL - k) * S +: S])) begin
        j = k;
        found = 1'b1;
      end
    end
  endtask

  task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic eq, input logic gt, input logic lt,
                         input logic tk, input int j);
    int n;
    logic seen;
    start = 1'b1;
    cond_op = op;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cond_op = 3'($urandom_range(0, 7));
    n = 0;
    seen = 1'b0;
    while (!seen && n < NSL + 4) begin
      tick();
      n++;
      if (done) seen = 1'b1;
      else chk({tag, " busy_in_cmp"}, busy, 1);
    end
    if (tk && model_count < CMAX) model_count++;
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " latency"}, n, j);
    chk({tag, " igual"}, igual, eq);
    chk({tag, " maior"}, maior, gt);
    chk({tag, " menor"}, menor, lt);
    chk({tag, " taken"}, update_UC_out, tk);
    chk({tag, " count"}, taken_count, model_count);
    tick();
    chk({tag, " done_low_after"}, done, 0);
    chk({tag, " busy_low_after"}, busy, 0);
    chk({tag, " taken_hold"}, update_UC_out, tk);
  endtask

  task automatic run_model(input string tag, input logic [2:0] op, input logic [31:0] x,
                           input logic [31:0] y);
    logic eq, gt, lt, tk;
    int j;
    model(op, x, y, eq, gt, lt, tk, j);
    run_req(tag, op, x, y, eq, gt, lt, tk, j);
  endtask

  vec_t vecs[10];

  initial begin
    int dones;
    logic [31:0] rx, ry;

    vecs[0] = '{3'b000, 32'h1234_5678, 32'h1234_5678, 1, 0, 0, 1, 4};
    vecs[1] = '{3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 0, 1, 1};
    vecs[2] = '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 1, 0, 1};
    vecs[3] = '{3'b100, 32'h0000_0010, 32'h0000_0011, 0, 0, 1, 1, 4};
    vecs[4] = '{3'b101, 32'h0000_0010, 32'h0000_0011, 0, 0, 1, 0, 4};
    vecs[5] = '{3'b001, 32'h0000_0005, 32'h0000_0005, 1, 0, 0, 0, 4};
    vecs[6] = '{3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 1, 1, 1};
    vecs[7] = '{3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1, 0, 0, 1};
    vecs[8] = '{3'b100, 32'h0012_0000, 32'h0013_0000, 0, 0, 1, 1, 2};
    vecs[9] = '{3'b101, 32'hFFFF_FF00, 32'hFFFF_FF00, 1, 0, 0, 1, 4};

    // Reset with a pending request: everything stays at zero.
    reset = 1'b1;
    start = 1'b1;
    clear_count = 1'b0;
    cond_op = 3'b000;
    a = 32'h1;
    b = 32'h1;
    repeat (3) tick();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst igual", igual, 0);
    chk("rst maior", maior, 0);
    chk("rst menor", menor, 0);
    chk("rst taken", update_UC_out, 0);
    chk("rst count", taken_count, 0);
    reset = 1'b0;
    start = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].eq,
              vecs[i].gt, vecs[i].lt, vecs[i].tk, vecs[i].j);
    end

    // Busy rejection: start held through CMP and DONE with other operands.
    start = 1'b1;
    cond_op = 3'b000;
    a = 32'h0000_0007;
    b = 32'h0000_0007;
    tick();
    cond_op = 3'b001;
    a = 32'h1;
    b = 32'h2;
    dones = 0;
    for (int i = 0; i < NSL + 4 && dones == 0; i++) begin
      tick();
      if (done) dones++;
    end
    chk("busy_rej first_done", dones, 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    if (model_count < CMAX) model_count++;
    chk("busy_rej done_count", dones, 1);
    chk("busy_rej igual", igual, 1);
    chk("busy_rej taken", update_UC_out, 1);
    chk("busy_rej count", taken_count, model_count);

    // Reset abort while in CMP.
    start = 1'b1;
    cond_op = 3'b000;
    a = 32'hABCD_0000;
    b = 32'hABCD_0000;
    tick();
    start = 1'b0;
    tick();
    chk("abort busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_count = 0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort igual", igual, 0);
    chk("abort taken", update_UC_out, 0);
    chk("abort count", taken_count, 0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    chk("abort no_done", dones, 0);
    run_model("after_abort", 3'b011, 32'h0000_0100, 32'h0000_00FF);

    // Saturation of the taken counter.
    for (int i = 0; i < 17; i++) begin
      rx = $urandom;
      run_model($sformatf("sat%0d", i), 3'b000, rx, rx);
    end
    chk("sat value", taken_count, CMAX);

    // Clear coinciding with a taken done edge.
    start = 1'b1;
    cond_op = 3'b000;
    a = 32'h55;
    b = 32'h55;
    tick();
    start = 1'b0;
    repeat (NSL - 1) tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    model_count = 0;
    chk("clear done", done, 1);
    chk("clear taken", update_UC_out, 1);
    chk("clear count", taken_count, 0);
    tick();

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      case ($urandom_range(0, 2))
        0:       ry = $urandom;
        1:       ry = rx;
        default: ry = rx ^ (32'h1 << $urandom_range(0, 31));
      endcase
      run_model($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), rx, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
